// File: rtl/wb_regfile.sv
// Write-back stage register file: 32x32 GPRs, $0 hardwired to zero, $29 reset to SP_INIT.
// Optional same-cycle write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_r_data_wb,
  input  logic [31:0] alu_result_wb,
  input  logic [31:0] link_addr_wb,
  input  logic [4:0]  reg_w_addr_wb,
  input  logic [2:0]  wb_ctrl_wb,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic [31:0] retire_cnt
);

  logic [31:0] regs_q [32];
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        we;

  // Link outranks mem_to_reg.
  always_comb begin
    if (wb_ctrl_wb[0])      wb_data = link_addr_wb;
    else if (wb_ctrl_wb[1]) wb_data = dm_r_data_wb;
    else                    wb_data = alu_result_wb;
  end

  assign we           = wb_ctrl_wb[2] && (reg_w_addr_wb != 5'd0);
  assign retire_cnt_d = retire_cnt_q + 32'd1;
  assign retire_cnt   = retire_cnt_q;

  function automatic logic [31:0] rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'h0 : regs_q[a];
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && (a == reg_w_addr_wb)) v = wb_data;
`endif
    return v;
  endfunction

  assign rs_data = rd(rs_addr);
  assign rt_data = rd(rt_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= (i == 29) ? SP_INIT : 32'h0;
      retire_cnt_q <= 32'h0;
    end else if (we) begin
      regs_q[reg_w_addr_wb] <= wb_data;
      retire_cnt_q          <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed scenarios plus random traffic against an array model.
module tb_wb_regfile;

  localparam logic [31:0] SP = 32'h0000_3FFC;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dm_r_data_wb, alu_result_wb, link_addr_wb;
  logic [4:0]  reg_w_addr_wb, rs_addr, rt_addr;
  logic [2:0]  wb_ctrl_wb;
  logic [31:0] rs_data, rt_data, wb_data, retire_cnt;

  wb_regfile #(.SP_INIT(SP)) dut (
    .clk(clk), .rst(rst),
    .dm_r_data_wb(dm_r_data_wb), .alu_result_wb(alu_result_wb), .link_addr_wb(link_addr_wb),
    .reg_w_addr_wb(reg_w_addr_wb), .wb_ctrl_wb(wb_ctrl_wb),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs, rt, wb, cnt;
    int          tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  logic [31:0] cnt_m;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mread(input logic [4:0] a, input bit wr,
                                        input logic [4:0] wa, input logic [31:0] wbv);
    if (a == 5'd0) return 32'h0;
    if (BYP && wr && a == wa) return wbv;
    return model[a];
  endfunction

  // One clock cycle of stimulus; expectation describes outputs before the edge.
  task automatic step(input bit r, input logic [2:0] c, input logic [4:0] wa,
                      input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] lk,
                      input logic [4:0] ars, input logic [4:0] art, input int tag, input bit chk);
    exp_t        e;
    logic [31:0] wbv;
    bit          wr;
    rst = r; wb_ctrl_wb = c; reg_w_addr_wb = wa;
    alu_result_wb = alu; dm_r_data_wb = dm; link_addr_wb = lk;
    rs_addr = ars; rt_addr = art;
    wbv = c[0] ? lk : (c[1] ? dm : alu);
    wr  = !r && c[2] && (wa != 5'd0);
    e.rs = mread(ars, wr, wa, wbv);
    e.rt = mread(art, wr, wa, wbv);
    e.wb = wbv;
    e.cnt = cnt_m;
    e.tag = tag;
    if (chk) sb.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? SP : 32'h0;
      cnt_m = 32'h0;
    end else if (wr) begin
      model[wa] = wbv;
      cnt_m = cnt_m + 32'd1;
    end
    #1;
  endtask

  task automatic preset_cnt();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    cnt_m = 32'hFFFF_FFFF;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 4;
      if (rs_data !== e.rs) begin
        errors++; $display("FAIL rs_data tag=%0d got=%h exp=%h", e.tag, rs_data, e.rs);
      end
      if (rt_data !== e.rt) begin
        errors++; $display("FAIL rt_data tag=%0d got=%h exp=%h", e.tag, rt_data, e.rt);
      end
      if (wb_data !== e.wb) begin
        errors++; $display("FAIL wb_data tag=%0d got=%h exp=%h", e.tag, wb_data, e.wb);
      end
      if (retire_cnt !== e.cnt) begin
        errors++; $display("FAIL retire_cnt tag=%0d got=%h exp=%h", e.tag, retire_cnt, e.cnt);
      end
    end
  end

  initial begin
    int waited;
    cnt_m = 32'h0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1; wb_ctrl_wb = 3'b000; reg_w_addr_wb = 5'd0;
    alu_result_wb = 32'h0; dm_r_data_wb = 32'h0; link_addr_wb = 32'h0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    @(posedge clk); #1;
    step(1, 3'b000, 5'd0, 0, 0, 0, 5'd0, 5'd0, 0, 0);

    // Reset state: $29 = SP_INIT, others zero, count zero.
    step(0, 3'b000, 5'd0, 0, 0, 0, 5'd29, 5'd5, 1, 1);
    // ALU write to $8, read back next cycle.
    step(0, 3'b100, 5'd8, 32'h1234_5678, 0, 0, 5'd0, 5'd0, 2, 1);
    step(0, 3'b000, 5'd0, 0, 0, 0, 5'd8, 5'd8, 3, 1);
    // Link priority, then mem_to_reg select.
    step(0, 3'b111, 5'd31, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0040_0008, 5'd0, 5'd0, 4, 1);
    step(0, 3'b110, 5'd10, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0040_0008, 5'd31, 5'd10, 5, 1);
    step(0, 3'b000, 5'd0, 0, 0, 0, 5'd10, 5'd31, 6, 1);
    // $0 write is discarded and not counted.
    step(0, 3'b100, 5'd0, 32'hDEAD_BEEF, 0, 0, 5'd0, 5'd0, 7, 1);
    step(0, 3'b000, 5'd0, 0, 0, 0, 5'd0, 5'd0, 8, 1);
    // Same-cycle read of register being written.
    step(0, 3'b100, 5'd9, 32'h0000_0011, 0, 0, 5'd0, 5'd0, 9, 1);
    step(0, 3'b100, 5'd9, 32'h0000_00FF, 0, 0, 5'd9, 5'd9, 10, 1);
    step(0, 3'b000, 5'd0, 0, 0, 0, 5'd9, 5'd0, 11, 1);
    // reg_write=0 ignores other control bits.
    step(0, 3'b011, 5'd9, 32'h7777_7777, 32'h6666_6666, 32'h5555_0000, 5'd9, 5'd9, 12, 1);
    // Reset beats a simultaneous write at a saturated count.
    step(0, 3'b100, 5'd4, 32'h0000_0042, 0, 0, 5'd0, 5'd0, 13, 1);
    preset_cnt();
    step(1, 3'b100, 5'd4, 32'h0000_0001, 0, 0, 5'd4, 5'd29, 14, 1);
    step(0, 3'b000, 5'd0, 0, 0, 0, 5'd4, 5'd29, 15, 1);
    // Counter wrap.
    preset_cnt();
    step(0, 3'b100, 5'd7, 32'h0000_0007, 0, 0, 5'd7, 5'd0, 16, 1);
    step(0, 3'b000, 5'd0, 0, 0, 0, 5'd7, 5'd0, 17, 1);

    // Random traffic, biased toward hitting written addresses.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, ars, art;
      wa  = 5'($urandom_range(0, 31));
      ars = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      art = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 40) == 0), 3'($urandom), wa, $urandom, $urandom, $urandom,
           ars, art, 100 + n, 1);
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter SP_INIT, default 32'h0000_0000: value loaded into register 29 by reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port dm_r_data_wb  input  32  data-memory read data from the MEM/WB register.
REQ-005 SHALL have port alu_result_wb  input  32  ALU result from the MEM/WB register.
REQ-006 SHALL have port link_addr_wb  input  32  return address for link instructions.
REQ-007 SHALL have port reg_w_addr_wb  input  5  destination register number.
REQ-008 SHALL have port wb_ctrl_wb  input  3  write-back controls: [2] reg_write, [1] mem_to_reg, [0] link.
REQ-009 SHALL have ports rs_addr and rt_addr  input  5  read-port addresses.
REQ-010 SHALL have ports rs_data and rt_data  output  32  read-port data, combinational from the address.
REQ-011 SHALL have port wb_data  output  32  selected write-back value, combinational.
REQ-012 SHALL have port retire_cnt  output  32  count of committed register writes.

Function
REQ-013 SHALL select wb_data as: link_addr_wb if link=1; else dm_r_data_wb if mem_to_reg=1; else alu_result_wb. Link takes priority over mem_to_reg.
REQ-014 SHALL hold 32 registers of 32 bits, indexed by 5-bit address.
REQ-015 SHALL write wb_data into register reg_w_addr_wb on the rising clk edge when reg_write=1 and rst=0.
REQ-016 SHALL ignore writes to register 0; a read of register 0 SHALL always return 32'h0.
REQ-017 SHALL return the stored register value on rs_data/rt_data one cycle after the committing edge, with no other read latency.
REQ-018 SHALL increment retire_cnt by 1 on each rising edge with reg_write=1 and reg_w_addr_wb!=0; writes to register 0 SHALL NOT count.
REQ-019 SHALL wrap retire_cnt from 32'hFFFF_FFFF to 32'h0 silently.
REQ-020 SHALL serve both read ports independently; both reading the same address SHALL return identical data.
REQ-021 SHALL treat wb_ctrl_wb values with reg_write=0 as no-ops regardless of bits [1:0].

Reset
REQ-022 SHALL, on a rising edge with rst=1, clear registers 1-28 and 30-31 to 32'h0, load register 29 with SP_INIT, and clear retire_cnt to 0.
REQ-023 SHALL give rst priority over a simultaneous write: no register write and no count increment occur on that edge.
REQ-024 SHALL keep wb_data and the read ports combinational during reset; they reflect the current register contents.

Configuration
REQ-025 SHALL support macro REGFILE_BYPASS_EN. When it is defined, a read whose address equals reg_w_addr_wb while reg_write=1, rst=0 and the address is not 0 SHALL return wb_data in the same cycle (write-through bypass).
REQ-026 SHALL, when REGFILE_BYPASS_EN is undefined, return the old stored value until the edge that commits the write.

Verification
REQ-027 Reset with SP_INIT=32'h0000_3FFC, then read rs=29 and rt=5 -> 32'h0000_3FFC and 32'h0; retire_cnt=0.
REQ-028 Write alu_result=32'h1234_5678 to $8 with ctrl=3'b100, then read $8 on the next cycle -> 32'h1234_5678; retire_cnt=1.
REQ-029 ctrl=3'b111 with dm=32'hAAAA_AAAA, alu=32'h5555_5555, link=32'h0040_0008 to $31 -> wb_data=32'h0040_0008 and $31 holds it; ctrl=3'b110 -> wb_data=32'hAAAA_AAAA.
REQ-030 Write 32'hDEAD_BEEF to $0 -> $0 reads 32'h0 and retire_cnt is unchanged.
REQ-031 Write 32'h0000_00FF to $9 while rs=9 in the same cycle -> rs_data=32'h0000_00FF with REGFILE_BYPASS_EN defined; old value without it.
REQ-032 Assert rst together with a write of 32'h1 to $4 and retire_cnt preset to 32'hFFFF_FFFF -> $4=0 and retire_cnt=0; separately, a write without reset at 32'hFFFF_FFFF -> retire_cnt wraps to 0.
